// File: rtl/apb_requester.sv
// apb_requester: APB4 requester that runs one transfer at a time.
// A valid/ready command port starts a transfer, the block drives the SETUP
// and ACCESS phases, and the result is returned on a valid/ready response port.
// Optional build macro APB_REQUESTER_TIMEOUT_EN adds an ACCESS-phase watchdog.
// The watchdog aborts a transfer after TIMEOUT_CYCLES consecutive PREADY=0 cycles.
// All outputs are registered and are loaded from the next state.
// This keeps the APB and handshake pins aligned with the FSM state.

module apb_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  // APB requester side
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic                  PREADY,
  input  logic [31:0]           PRDATA,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = 16;

  // Reject watchdog limits that the 16-bit counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_n;
  logic   accept_c;
  logic   done_c;
  logic   abort_c;

`ifdef APB_REQUESTER_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;
`endif

  // Next-state decode, plus one-cycle strobes for command accept,
  // normal completion and watchdog abort.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    done_c   = 1'b0;
    abort_c  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_c = 1'b1;
          state_n  = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done_c  = 1'b1;
          state_n = RESP;
        end
`ifdef APB_REQUESTER_TIMEOUT_EN
        else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_c = 1'b1;
          state_n = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  // APB pins: the command is latched straight into PADDR/PWRITE/PWDATA/PSTRB.
  // PSTRB is forced to 0 for reads and whenever no transfer is in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else begin
      PSEL    <= (state_n == SETUP) || (state_n == ACCESS);
      PENABLE <= (state_n == ACCESS);
      if (accept_c) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
        PSTRB  <= cmd_write ? cmd_strb : 4'b0;
      end else if ((state_n == RESP) || (state_n == IDLE)) begin
        PSTRB  <= 4'b0;
      end
    end
  end

  // Handshake flags and response capture; response fields persist until the next capture.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      cmd_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      if (done_c) begin
        rsp_rdata  <= PWRITE ? 32'h0 : PRDATA;
        rsp_slverr <= PSLVERR;
      end else if (abort_c) begin
        rsp_rdata  <= 32'h0;
        rsp_slverr <= 1'b1;
      end
    end
  end

`ifdef APB_REQUESTER_TIMEOUT_EN
  // Watchdog: held at 0 outside ACCESS and counts stalled ACCESS cycles.
  always_ff @(posedge PCLK) begin
    if (PRESET)                 wd_cnt <= '0;
    else if (state != ACCESS)   wd_cnt <= '0;
    else if (!PREADY)           wd_cnt <= wd_cnt + CNT_W'(1);
  end

  // Timeout flag follows each capture.
  always_ff @(posedge PCLK) begin
    if (PRESET)       rsp_timeout <= 1'b0;
    else if (done_c)  rsp_timeout <= 1'b0;
    else if (abort_c) rsp_timeout <= 1'b1;
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (master) that drives a single APB completer over PCLK-domain signals.
- Accepts one transfer at a time on a valid/ready command port and sequences the APB SETUP and ACCESS phases.
- Returns read data and error status on a valid/ready response port.
- Sits between a test sequencer or register-access engine and any APB completer under test.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and PADDR
TIMEOUT_CYCLES, 16, consecutive ACCESS cycles with PREADY=0 before abort (used only with APB_REQUESTER_TIMEOUT_EN); legal range 1..65535

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when both high
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_write  input  1  1=write, 0=read
cmd_wdata  input  32  write data
cmd_strb  input  4  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when both high
rsp_rdata  output  32  read data (0 for writes)
rsp_slverr  output  1  completer error or timeout
rsp_timeout  output  1  transfer aborted by watchdog
PADDR  output  ADDR_WIDTH  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  32  APB write data
PSTRB  output  4  APB strobes
PREADY  input  1  completer ready
PRDATA  input  32  completer read data
PSLVERR  input  1  completer error

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset (PRESET=1 at a PCLK edge):
  - state returns to IDLE;
  - every output is 0, except cmd_ready, which is 1;
  - the watchdog counter is cleared.
- Reset mid-transfer: PSEL and PENABLE drop on that same edge; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid&&cmd_ready, latch addr/write/wdata/strb and go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - PADDR, PWRITE and PWDATA come from the latched command.
  - PSTRB = latched strb for writes; PSTRB = 4'b0 for reads (APB4 rule).
  - Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; all APB outputs held stable.
  - If PREADY=1: capture rsp_rdata (PRDATA for reads, 0 for writes) and rsp_slverr=PSLVERR, then go to RESP.
  - If PREADY=0: remain in ACCESS.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1; rsp_* held stable.
  - On rsp_ready=1, go to IDLE and drop rsp_valid.
  - rsp_ready high in the same cycle rsp_valid first rises is legal and completes the handshake.
- Latency:
  - Zero-wait-state transfer: PSEL rises 1 cycle after command acceptance; rsp_valid rises 2 cycles after PSEL rises.
  - Each PREADY=0 ACCESS cycle adds 1 cycle.
  - Minimum issue interval is 4 cycles with rsp_ready tied high.
- Between transfers, PADDR, PWRITE and PWDATA hold their last values; PSTRB returns to 0.
- PRDATA and PSLVERR are sampled only in ACCESS when PREADY=1; ignored otherwise.
- cmd_valid while cmd_ready=0 is ignored; no queueing.
- rsp_rdata, rsp_slverr and rsp_timeout keep their values after the response handshake, until the next capture.

Optional Feature:
APB_REQUESTER_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts on that edge: go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 in the abort cycle wins: normal completion, no timeout.
- Undefined: no counter; rsp_timeout is tied to 0; ACCESS may wait indefinitely.

Test Plan:
- Reset sanity: hold PRESET=1 for 3 cycles -> PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1, PSTRB=0.
- Zero-wait write: cmd addr=0x10, write=1, wdata=0xDEADBEEF, strb=4'hF; PREADY=1 -> SETUP with PSEL=1/PENABLE=0, then 1 ACCESS cycle; rsp_valid 2 cycles after PSEL rises; rsp_rdata=0, rsp_slverr=0.
- Wait-state read: cmd addr=0x4, write=0, strb=4'hF; PREADY low 3 cycles, then high with PRDATA=0x12345678 -> PSTRB=0 throughout; ACCESS lasts 4 cycles; rsp_rdata=0x12345678; PADDR stable for the whole transfer.
- Error plus response backpressure: PSLVERR=1 with PREADY=1 on a read; rsp_ready held 0 for 5 cycles -> rsp_slverr=1 held stable; cmd_ready=0 until the handshake; a cmd_valid pulse during RESP is not accepted.
- Reset mid-ACCESS: PREADY=0, PRESET=1 for 1 cycle -> PSEL and PENABLE are 0 after that edge, no rsp_valid; the next command completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=4): PREADY held 0 -> abort after exactly 4 stalled ACCESS cycles; rsp_timeout=1, rsp_slverr=1, rsp_rdata=0. Macro undefined: the same stimulus stays in ACCESS for more than 100 cycles.
